// File: rtl/uart_rx_ctrl.sv
// Receive-side UART controller: handshakes bytes from a receiver into a small FIFO
// and exposes DATA/STATUS/CTRL/COUNT registers plus a level interrupt to a bus.
module uart_rx_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_data_ready,
   output logic        rx_data_ack,
   input  logic [1:0]  addr,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_COUNT  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACK   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            ack_q, ack_d;
   logic            en_q, en_d;
   logic            irqEn_q, irqEn_d;
   logic            ovr_q, ovr_d;
   logic            irq_q, irq_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [AW-1:0]   wrPtr_q, wrPtr_d;
   logic [AW-1:0]   rdPtr_q, rdPtr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      mem_q [DEPTH];

   logic            capture;
   logic            notEmpty;
   logic            full;
   logic            pop;
   logic            push;
   logic            ovrSet;
   logic            flush;
   logic            unusedWdata;

   assign unusedWdata = ^wdata[31:3];

   assign notEmpty = (count_q != '0);
   assign full     = (count_q == CW'(DEPTH));

   // Handshake FSM: one capture per ready assertion, then wait for the receiver to drop ready.
   always_comb begin
      state_d = IDLE;
      ack_d   = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (en_q && rx_data_ready) begin
               capture = 1'b1;
               ack_d   = 1'b1;
               state_d = ACK;
            end else begin
               state_d = IDLE;
            end
         end
         ACK:     state_d = DRAIN;
         DRAIN:   state_d = rx_data_ready ? DRAIN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A full FIFO still accepts a byte when the same cycle pops the head.
   always_comb begin
      pop    = rd_en && (addr == ADDR_DATA) && notEmpty;
      push   = capture && (!full || pop);
      ovrSet = capture && full && !pop;
      flush  = wr_en && (addr == ADDR_CTRL) && wdata[2];

      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
      end

      en_d    = en_q;
      irqEn_d = irqEn_q;
      if (wr_en && (addr == ADDR_CTRL)) begin
         en_d    = wdata[0];
         irqEn_d = wdata[1];
      end

      ovr_d = ovr_q;
      if (wr_en && (addr == ADDR_STATUS) && wdata[2]) begin
         ovr_d = 1'b0;
      end
      if (ovrSet) begin
         ovr_d = 1'b1;
      end

      rdata_d = rdata_q;
      if (rd_en) begin
         case (addr)
            ADDR_DATA:   rdata_d = pop ? {24'd0, mem_q[rdPtr_q]} : 32'd0;
            ADDR_STATUS: rdata_d = {28'd0, (state_q != IDLE), ovr_q, full, notEmpty};
            ADDR_CTRL:   rdata_d = {30'd0, irqEn_q, en_q};
            ADDR_COUNT:  rdata_d = {{(32 - CW){1'b0}}, count_q};
            default:     rdata_d = 32'd0;
         endcase
      end

      irq_d = irqEn_q && (notEmpty || ovr_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         en_q    <= 1'b0;
         irqEn_q <= 1'b0;
         ovr_q   <= 1'b0;
         irq_q   <= 1'b0;
         rdata_q <= 32'd0;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         en_q    <= en_d;
         irqEn_q <= irqEn_d;
         ovr_q   <= ovr_d;
         irq_q   <= irq_d;
         rdata_q <= rdata_d;
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= rx_data;
      end
   end

   assign rx_data_ack = ack_q;
   assign rdata       = rdata_q;
   assign irq         = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a behavioural FIFO model predicts every DATA read,
// while register reads, handshake timing, irq and reset behaviour are checked against constants.
module tb_uart_rx_ctrl;

   logic        clk;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_data_ready;
   logic        rx_data_ack;
   logic [1:0]  addr;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int checkCount = 0;
   int passCount  = 0;

   logic [7:0] expFifo [$];
   bit         expOvr;

   localparam int MODEL_DEPTH = 4;

   uart_rx_ctrl #(.DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_data_ready (rx_data_ready),
      .rx_data_ack   (rx_data_ack),
      .addr          (addr),
      .rd_en         (rd_en),
      .wr_en         (wr_en),
      .wdata         (wdata),
      .rdata         (rdata),
      .irq           (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] modelPop();
      logic [7:0] b;
      if (expFifo.size() == 0) return 32'd0;
      b = expFifo.pop_front();
      return {24'd0, b};
   endfunction

   // Returns 1 when the model sees an overrun (byte dropped).
   function automatic bit modelPush(input logic [7:0] b);
      if (expFifo.size() < MODEL_DEPTH) begin
         expFifo.push_back(b);
         return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic readReg(input logic [1:0] a, output logic [31:0] v);
      @(posedge clk); #1;
      rd_en = 1'b1;
      addr  = a;
      @(posedge clk); #1;
      rd_en = 1'b0;
      v = rdata;
   endtask

   task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      wr_en = 1'b1;
      addr  = a;
      wdata = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic checkReg(input string tag, input logic [1:0] a, input logic [31:0] expected);
      logic [31:0] v;
      readReg(a, v);
      checkOutput(tag, v, expected);
   endtask

   task automatic readData(input string tag);
      logic [31:0] v;
      logic [31:0] e;
      readReg(2'd0, v);
      e = modelPop();
      checkOutput(tag, v, e);
   endtask

   // Drives one byte through the receiver handshake, optionally with a same-cycle
   // DATA read or STATUS ovr-clear, and checks the one-cycle acknowledge.
   task automatic applyStimulus(input logic [7:0] b, input bit withRead, input bit withClr, input string tag);
      logic [31:0] readExp;
      bit          over;
      bit          acked;
      readExp = 32'd0;
      @(posedge clk); #1;
      rx_data       = b;
      rx_data_ready = 1'b1;
      if (withRead) begin
         rd_en = 1'b1;
         addr  = 2'd0;
         readExp = modelPop();
      end
      if (withClr) begin
         wr_en = 1'b1;
         addr  = 2'd1;
         wdata = 32'h4;
      end
      over = modelPush(b);
      if (over) expOvr = 1'b1;
      else if (withClr) expOvr = 1'b0;
      @(posedge clk); #1;
      rd_en = 1'b0;
      wr_en = 1'b0;
      if (withRead) checkOutput({tag, "_rd"}, rdata, readExp);
      acked = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rx_data_ack) begin
            acked = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      checkOutput({tag, "_ack"}, {31'd0, acked}, 32'd1);
      rx_data_ready = 1'b0;
      rx_data       = 8'h00;
      @(posedge clk); #1;
      checkOutput({tag, "_ack1cyc"}, {31'd0, rx_data_ack}, 32'd0);
   endtask

   initial begin
      logic [31:0] v;
      int          ackPulses;

      reset         = 1'b1;
      rx_data       = 8'h00;
      rx_data_ready = 1'b0;
      addr          = 2'd0;
      rd_en         = 1'b0;
      wr_en         = 1'b0;
      wdata         = 32'd0;
      expOvr        = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstAck", {31'd0, rx_data_ack}, 32'd0);
      checkOutput("rstRdata", rdata, 32'd0);
      checkOutput("rstIrq", {31'd0, irq}, 32'd0);
      reset = 1'b0;
      checkReg("rstStatus", 2'd1, 32'd0);
      checkReg("rstCtrl", 2'd2, 32'd0);
      checkReg("rstCount", 2'd3, 32'd0);

      // Disabled controller must ignore a pending byte.
      @(posedge clk); #1;
      rx_data = 8'h99;
      rx_data_ready = 1'b1;
      ackPulses = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (rx_data_ack) ackPulses++;
      end
      rx_data_ready = 1'b0;
      checkOutput("disabledAcks", ackPulses, 0);
      checkReg("disabledCount", 2'd3, 32'd0);

      // Single byte round trip.
      writeReg(2'd2, 32'h1);
      checkReg("ctrlEn", 2'd2, 32'h1);
      applyStimulus(8'hA5, 1'b0, 1'b0, "single");
      checkReg("singleCount1", 2'd3, 32'd1);
      readData("singleData");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rdataHold", rdata, 32'h0000_00A5);
      checkReg("singleCount0", 2'd3, 32'd0);

      // Overflow: five bytes into four entries.
      for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b0, 1'b0, "fill");
      checkReg("ovfStatus", 2'd1, 32'h7);
      for (int i = 0; i < 4; i++) readData("ovfData");
      readData("emptyRead");
      checkReg("ovrSticky", 2'd1, {29'd0, expOvr, 2'b00});
      writeReg(2'd1, 32'h4);
      expOvr = 1'b0;
      checkReg("ovrCleared", 2'd1, 32'd0);

      // Full FIFO with a same-cycle pop accepts the new byte.
      for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i), 1'b0, 1'b0, "fill2");
      applyStimulus(8'h5A, 1'b1, 1'b0, "popPush");
      checkReg("popPushCount", 2'd3, 32'd4);
      checkReg("popPushStatus", 2'd1, 32'h3);
      for (int i = 0; i < 4; i++) readData("popPushData");

      // Interrupt follows irq_en & (not_empty | ovr).
      writeReg(2'd2, 32'h3);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("irqEmpty", {31'd0, irq}, 32'd0);
      applyStimulus(8'h77, 1'b0, 1'b0, "irqByte");
      repeat (2) @(posedge clk);
      #1;
      checkOutput("irqSet", {31'd0, irq}, 32'd1);
      readData("irqData");
      repeat (2) @(posedge clk);
      #1;
      checkOutput("irqClr", {31'd0, irq}, 32'd0);

      // Flush through CTRL and ovr clear racing an overrun.
      for (int i = 0; i < 3; i++) applyStimulus(8'h20 + 8'(i), 1'b0, 1'b0, "flushFill");
      checkReg("preFlushCount", 2'd3, 32'd3);
      writeReg(2'd2, 32'h5);
      expFifo.delete();
      checkReg("flushCount", 2'd3, 32'd0);
      checkReg("flushCtrl", 2'd2, 32'h1);
      for (int i = 0; i < 4; i++) applyStimulus(8'h30 + 8'(i), 1'b0, 1'b0, "raceFill");
      applyStimulus(8'hEE, 1'b0, 1'b1, "race");
      checkReg("raceStatus", 2'd1, {29'd0, expOvr, 2'b11});
      writeReg(2'd1, 32'h4);
      expOvr = 1'b0;
      checkReg("raceCleared", 2'd1, 32'h3);
      readData("raceData");

      // Reset in the middle of the acknowledge.
      @(posedge clk); #1;
      rx_data = 8'hC3;
      rx_data_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("preRstAck", {31'd0, rx_data_ack}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("midRstAck", {31'd0, rx_data_ack}, 32'd0);
      checkOutput("midRstRdata", rdata, 32'd0);
      checkOutput("midRstIrq", {31'd0, irq}, 32'd0);
      expFifo.delete();
      expOvr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      ackPulses = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (rx_data_ack) ackPulses++;
      end
      checkOutput("postRstNoAck", ackPulses, 0);
      checkReg("postRstCtrl", 2'd2, 32'd0);
      checkReg("postRstCount", 2'd3, 32'd0);
      writeReg(2'd2, 32'h1);
      ackPulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (rx_data_ack) ackPulses++;
         @(posedge clk); #1;
      end
      checkOutput("heldReadyAcks", ackPulses, 1);
      checkReg("heldBusy", 2'd1, 32'h9);
      rx_data_ready = 1'b0;
      void'(modelPush(8'hC3));
      repeat (2) @(posedge clk);
      checkReg("heldCount", 2'd3, 32'd1);
      readData("heldData");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  8  received byte from the receiver.
REQ-005 SHALL have port rx_data_ready  input  1  receiver byte valid; held until acknowledged.
REQ-006 SHALL have port rx_data_ack  output  1  one-cycle acknowledge to the receiver; the receiver clears ready and data on the next edge.
REQ-007 SHALL have port addr  input  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 COUNT.
REQ-008 SHALL have port rd_en  input  1  bus read strobe.
REQ-009 SHALL have port wr_en  input  1  bus write strobe.
REQ-010 SHALL have port wdata  input  32  bus write data.
REQ-011 SHALL have port rdata  output  32  registered bus read data.
REQ-012 SHALL have port irq  output  1  level interrupt.

Function
REQ-013 SHALL implement states IDLE, ACK, DRAIN, encoded in 2 bits; any illegal encoding returns to IDLE.
REQ-014 IDLE: if CTRL.en=1 and rx_data_ready=1, SHALL capture rx_data on that edge, set rx_data_ack<=1 and go to ACK; otherwise stay.
REQ-015 Capture when the FIFO is not full, or is full with a same-cycle DATA pop, SHALL push rx_data.
REQ-016 Capture when the FIFO is full with no same-cycle pop SHALL drop the byte and set sticky STATUS.ovr.
REQ-017 ACK: rx_data_ack SHALL be 1 for exactly this one cycle; SHALL go to DRAIN with rx_data_ack<=0.
REQ-018 DRAIN: SHALL stay while rx_data_ready=1 and go to IDLE when rx_data_ready=0; no byte is captured twice.
REQ-019 Clearing CTRL.en during ACK or DRAIN SHALL NOT abort the handshake; only new captures from IDLE are gated.
REQ-020 Read of DATA (rd_en, addr=0) SHALL return the FIFO head in rdata[7:0] one cycle later and pop it; an empty read SHALL return 0 with no pointer change.
REQ-021 STATUS read SHALL return bit0=not_empty, bit1=full, bit2=ovr, bit3=busy (state!=IDLE), other bits 0.
REQ-022 CTRL read SHALL return bit0=en, bit1=irq_en; COUNT read SHALL return the occupancy 0..DEPTH in the low bits.
REQ-023 All read-data bits not defined above SHALL be 0; rdata SHALL hold its value when rd_en=0.
REQ-024 A CTRL write SHALL load en=wdata[0] and irq_en=wdata[1].
REQ-025 A CTRL write with wdata[2]=1 SHALL flush the FIFO (pointers and count to 0) that edge, overriding a same-cycle push or pop.
REQ-026 A STATUS write with wdata[2]=1 SHALL clear ovr; a same-cycle overrun SHALL win, leaving ovr=1.
REQ-027 Writes to DATA and COUNT SHALL be ignored.
REQ-028 Simultaneous rd_en and wr_en SHALL perform both operations.
REQ-029 Pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-030 A same-cycle push and pop SHALL leave the count unchanged.
REQ-031 irq SHALL be registered and equal irq_en & (not_empty | ovr).

Reset
REQ-032 On reset=1, regardless of clk, SHALL force state=IDLE, rx_data_ack=0, rdata=0, irq=0, en=0, irq_en=0, ovr=0, pointers and count=0.
REQ-033 Reset asserted mid-handshake SHALL drop the in-flight ack; after release, a still-asserted rx_data_ready SHALL be captured once when en=1.

Verification
REQ-034 en=1; rx_data=8'hA5 with ready high 1 cycle -> ack high exactly 1 cycle; COUNT=1; DATA read gives rdata=32'h000000A5 next cycle; COUNT=0.
REQ-035 DEPTH=4; push 5 bytes 01..05 with no reads -> STATUS=32'h7 (not_empty, full, ovr); reads return 01,02,03,04; fifth read returns 0.
REQ-036 FIFO full and byte 0x5A arrives on the same cycle as a DATA read -> no overrun; COUNT stays 4; 0x5A is read last.
REQ-037 irq_en=1, FIFO empty -> irq=0; push 1 byte -> irq=1 one cycle after push; read it -> irq=0.
REQ-038 CTRL write 32'h5 with COUNT=3 -> COUNT=0, en=1; STATUS write 32'h4 clears ovr unless an overrun coincides.
REQ-039 Assert reset during ACK -> ack=0 immediately and all registers at reset values; after release with en=1 and ready held, exactly one capture occurs.
